// File: rtl/rel_arb_pkg.sv
// rel_arb_pkg: shared state type and round-robin pick helper for the rel_fifo push arbiter
package rel_arb_pkg;
  localparam int unsigned MaxReq = 32;
  localparam int unsigned MaxIdxWidth = 5;
  typedef logic [MaxIdxWidth-1:0] idx_t;
  typedef struct packed {
    logic lock;
    idx_t ptr;
    idx_t idx;
  } arb_state_t;
  typedef struct packed {
    logic found;
    idx_t idx;
  } pick_t;
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic pick_t rr_pick(input logic [MaxReq-1:0] valid, input idx_t ptr,
                                    input int unsigned n);
    pick_t p;
    int unsigned j;
    p = '{found: 1'b0, idx: ptr};
    for (int unsigned i = 0; i < MaxReq; i++) begin
      j = 32'(ptr) + i;
      if (j >= n) j = j - n;
      if (i < n && !p.found && valid[j[MaxIdxWidth-1:0]]) begin
        p.found = 1'b1;
        p.idx = j[MaxIdxWidth-1:0];
      end
    end
    return p;
  endfunction
  function automatic idx_t wrap_inc(input idx_t k, input int unsigned n);
    return (32'(k) == n - 1) ? '0 : k + idx_t'(1);
  endfunction
endpackage

// File: rtl/rel_fifo_push_arbiter_tmr_part.sv
// rel_fifo_push_arbiter_tmr_part: one redundant copy of the arbitration state, fed by the voted state
module rel_fifo_push_arbiter_tmr_part
  import rel_arb_pkg::*;
#(
  parameter int unsigned NumReq    = 4,
  parameter bit          LockGrant = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              full_i,
  input  logic [NumReq-1:0] valid_i,
  input  arb_state_t        voted_i,
  output arb_state_t        state_o,
  output idx_t              gnt_o,
  output logic              push_o
);
  arb_state_t state_d, state_q;
  pick_t pick;
  logic [MaxReq-1:0] valid_ext;
  logic gnt_valid;
  always_comb begin
    valid_ext = MaxReq'(valid_i);
    pick = voted_i.lock ? '{found: 1'b1, idx: voted_i.idx} : rr_pick(valid_ext, voted_i.ptr, NumReq);
    gnt_valid = pick.found && valid_ext[pick.idx];
    push_o = rst_ni && gnt_valid && !full_i && !flush_i;
    state_d = voted_i;
    if (flush_i) state_d = '0;
    else if (push_o) state_d = '{lock: 1'b0, ptr: wrap_inc(pick.idx, NumReq), idx: pick.idx};
    else if (LockGrant && gnt_valid && full_i) state_d = '{lock: 1'b1, ptr: voted_i.ptr, idx: pick.idx};
    else if (voted_i.lock && !gnt_valid) state_d.lock = 1'b0;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= '0;
    else state_q <= state_d;
  end
  assign state_o = state_q;
  assign gnt_o = pick.idx;
endmodule

// File: rtl/rel_fifo_push_arbiter.sv
// rel_fifo_push_arbiter: round-robin push-port arbiter with triplicated, majority-voted state
module rel_fifo_push_arbiter
  import rel_arb_pkg::*;
#(
  parameter int unsigned NumReq    = 4,
  parameter int unsigned DataWidth = 32,
  parameter bit          TmrStatus = 1'b0,
  parameter bit          LockGrant = 1'b1,
  localparam int unsigned IdxWidth = idx_width(NumReq),
  localparam int unsigned HsWidth  = TmrStatus ? 3 : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [HsWidth-1:0]               flush_i,
  input  logic [NumReq-1:0]                req_valid_i,
  output logic [NumReq-1:0]                req_ready_o,
  input  logic [NumReq-1:0][DataWidth-1:0] req_data_i,
  input  logic [HsWidth-1:0]               fifo_full_i,
  output logic [HsWidth-1:0]               fifo_push_o,
  output logic [DataWidth-1:0]             fifo_data_o,
  output logic [HsWidth-1:0]               fifo_flush_o,
  output logic [IdxWidth-1:0]              gnt_idx_o,
  output logic                             fault_o
);
  arb_state_t state [3];
  idx_t gnt [3];
  logic [2:0] push;
  arb_state_t voted;
  logic voted_push;
  logic [IdxWidth-1:0] ga, gb, gc;
  logic [MaxReq-1:0] valid_ext;
  for (genvar i = 0; i < 3; i++) begin : g_part
    (* no_ungroup *)
    rel_fifo_push_arbiter_tmr_part #(
      .NumReq   (NumReq),
      .LockGrant(LockGrant)
    ) u_part (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .flush_i(flush_i[TmrStatus ? i : 0]),
      .full_i (fifo_full_i[TmrStatus ? i : 0]),
      .valid_i(req_valid_i),
      .voted_i(voted),
      .state_o(state[i]),
      .gnt_o  (gnt[i]),
      .push_o (push[i])
    );
  end
  always_comb begin
    voted = (state[0] & state[1]) | (state[0] & state[2]) | (state[1] & state[2]);
    voted_push = (push[0] & push[1]) | (push[0] & push[2]) | (push[1] & push[2]);
    ga = gnt[0][IdxWidth-1:0];
    gb = gnt[1][IdxWidth-1:0];
    gc = gnt[2][IdxWidth-1:0];
    gnt_idx_o = (ga & gb) | (ga & gc) | (gb & gc);
    fault_o = |(state[0] ^ state[1]) || |(state[0] ^ state[2]) ||
              |(gnt[0] ^ gnt[1]) || |(gnt[0] ^ gnt[2]) ||
              (push[0] != push[1]) || (push[0] != push[2]);
    fifo_data_o = req_data_i[gnt_idx_o];
    req_ready_o = '0;
    req_ready_o[gnt_idx_o] = voted_push;
    valid_ext = MaxReq'(req_valid_i);
  end
  if (TmrStatus) begin : g_push_tmr
    assign fifo_push_o = push;
  end else begin : g_push_single
    assign fifo_push_o = voted_push;
  end
  assign fifo_flush_o = flush_i;
  // A locked requester must hold valid until its push completes
  a_lock_holds_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    voted.lock |-> valid_ext[voted.idx]);
endmodule

// File: tb/tb_rel_fifo_push_arbiter.sv
// tb_rel_fifo_push_arbiter: table-driven directed checks plus hand-written TMR/fault/reset sequences
module tb_rel_fifo_push_arbiter;
  import rel_arb_pkg::*;
  typedef struct {
    logic [3:0] valid;
    logic       full;
    logic       flush;
    logic [3:0] ready;
    logic       push;
    logic [1:0] gnt;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [0:0] flush = '0, full = '0, push_o, flush_o;
  logic [3:0] valid = '0, ready;
  logic [3:0][31:0] data;
  logic [31:0] fdata, fdata2;
  logic [1:0] gnt, gnt2;
  logic fault, fault2;
  logic [2:0] flush2 = '0, full2 = '0, push2, flush_o2;
  logic [3:0] valid2 = '0, ready2;
  int passes = 0, total = 0;
  vec_t vecs [17];
  arb_state_t inj;
  always #5 clk = ~clk;
  rel_fifo_push_arbiter #(.NumReq(4), .DataWidth(32), .TmrStatus(1'b0), .LockGrant(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .req_valid_i(valid), .req_ready_o(ready),
    .req_data_i(data), .fifo_full_i(full), .fifo_push_o(push_o), .fifo_data_o(fdata),
    .fifo_flush_o(flush_o), .gnt_idx_o(gnt), .fault_o(fault));
  rel_fifo_push_arbiter #(.NumReq(4), .DataWidth(32), .TmrStatus(1'b1), .LockGrant(1'b1)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush2), .req_valid_i(valid2), .req_ready_o(ready2),
    .req_data_i(data), .fifo_full_i(full2), .fifo_push_o(push2), .fifo_data_o(fdata2),
    .fifo_flush_o(flush_o2), .gnt_idx_o(gnt2), .fault_o(fault2));
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  initial begin
    for (int k = 0; k < 4; k++) data[k] = 32'hD000_0000 + 32'(k);
    vecs[0]  = '{4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0};
    vecs[1]  = '{4'b1111, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1};
    vecs[2]  = '{4'b1111, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd2};
    vecs[3]  = '{4'b1111, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd3};
    vecs[4]  = '{4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0};
    vecs[5]  = '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd1};
    vecs[6]  = '{4'b0100, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd2};
    vecs[7]  = '{4'b0010, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd1};
    vecs[8]  = '{4'b0011, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd1};
    vecs[9]  = '{4'b0011, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd1};
    vecs[10] = '{4'b0011, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1};
    vecs[11] = '{4'b0011, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0};
    vecs[12] = '{4'b1111, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd1};
    vecs[13] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
    vecs[14] = '{4'b1000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd3};
    vecs[15] = '{4'b1000, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd3};
    vecs[16] = '{4'b0001, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0};
    #12;
    valid = 4'b1111;
    #1;
    check("reset_ready", 32'(ready), 32'h0);
    check("reset_push", 32'(push_o), 32'h0);
    check("reset_gnt", 32'(gnt), 32'h0);
    check("reset_fault", 32'(fault), 32'h0);
    valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      valid = vecs[i].valid;
      full = vecs[i].full;
      flush = vecs[i].flush;
      #2;
      check($sformatf("v%0d_ready", i), 32'(ready), 32'(vecs[i].ready));
      check($sformatf("v%0d_push", i), 32'(push_o), 32'(vecs[i].push));
      check($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
      check($sformatf("v%0d_data", i), fdata, 32'hD000_0000 + 32'(vecs[i].gnt));
      check($sformatf("v%0d_fault", i), 32'(fault), 32'h0);
      check($sformatf("v%0d_flush", i), 32'(flush_o), 32'(vecs[i].flush));
    end
    // return pointer to 0, then upset copy 1's pointer
    @(negedge clk);
    valid = '0;
    full = '0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    valid = 4'b1111;
    inj = '0;
    inj.ptr = idx_t'(3);
    force dut.g_part[1].u_part.state_q = inj;
    #2;
    check("upset_fault", 32'(fault), 32'h1);
    check("upset_gnt", 32'(gnt), 32'h0);
    check("upset_ready", 32'(ready), 32'h1);
    release dut.g_part[1].u_part.state_q;
    @(negedge clk);
    valid = '0;
    #2;
    check("heal_fault", 32'(fault), 32'h0);
    check("heal_ptr0", 32'(dut.g_part[0].u_part.state_q.ptr), 32'h1);
    check("heal_ptr1", 32'(dut.g_part[1].u_part.state_q.ptr), 32'h1);
    check("heal_ptr2", 32'(dut.g_part[2].u_part.state_q.ptr), 32'h1);
    // asynchronous reset in the middle of a handshake
    @(negedge clk);
    valid = 4'b1111;
    #2;
    check("pre_rst_gnt", 32'(gnt), 32'h1);
    check("pre_rst_push", 32'(push_o), 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_push", 32'(push_o), 32'h0);
    check("mid_rst_ready", 32'(ready), 32'h0);
    check("mid_rst_gnt", 32'(gnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    check("post_rst_gnt", 32'(gnt), 32'h0);
    check("post_rst_push", 32'(push_o), 32'h1);
    @(negedge clk);
    valid = '0;
    // per-copy full bits on the TMR-status instance
    valid2 = 4'b0001;
    full2 = 3'b000;
    #2;
    check("tmr_push_all", 32'(push2), 32'h7);
    check("tmr_ready_all", 32'(ready2), 32'h1);
    check("tmr_fault_none", 32'(fault2), 32'h0);
    @(negedge clk);
    full2 = 3'b010;
    #2;
    check("tmr_push_split", 32'(push2), 32'h5);
    check("tmr_ready_split", 32'(ready2), 32'h1);
    check("tmr_fault_split", 32'(fault2), 32'h1);
    check("tmr_gnt_split", 32'(gnt2), 32'h0);
    flush2 = 3'b111;
    #1;
    check("tmr_flush_push", 32'(push2), 32'h0);
    check("tmr_flush_out", 32'(flush_o2), 32'h7);
    @(negedge clk);
    valid2 = '0;
    full2 = '0;
    flush2 = '0;
    @(negedge clk);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
